// File: rtl/phase_clockgen.sv
// Two-phase non-overlapping clock generator for MCS-4 systems: derives clk1/clk2 and
// lead-compensated clk1_ext/clk2_ext from sysclk, runs the A1..X3 subcycle counter and SYNC.
module phase_clockgen #(
   parameter int SYSCLK_TCY   = 20,
   parameter int CLK_TCY      = 1350,
   parameter int PHI1_TPW     = 380,
   parameter int PHI_D1       = 400,
   parameter int PHI2_TPW     = 380,
   parameter int EXT_CLK_PROP = 4
) (
   input  logic       sysclk,
   input  logic       sysrst_n,
   input  logic       run,
   output logic       clk1,
   output logic       clk2,
   output logic       clk1_ext,
   output logic       clk2_ext,
   output logic [2:0] subcycle,
   output logic       sync,
   output logic       running
);

   localparam int N   = (CLK_TCY  + SYSCLK_TCY - 1) / SYSCLK_TCY;
   localparam int P1  = (PHI1_TPW + SYSCLK_TCY - 1) / SYSCLK_TCY;
   localparam int G1  = (PHI_D1   + SYSCLK_TCY - 1) / SYSCLK_TCY;
   localparam int P2  = (PHI2_TPW + SYSCLK_TCY - 1) / SYSCLK_TCY;
   localparam int E   = EXT_CLK_PROP;
   localparam int G2  = N - P1 - G1 - P2;
   localparam int C2R = P1 + G1;
   localparam int C2F = P1 + G1 + P2;
   localparam int W   = $clog2(N);

   localparam logic [W-1:0] C_LAST   = W'(N - 1);
   localparam logic [W-1:0] C_SAMPLE = W'(C2F - 1);
   localparam logic [W-1:0] P1_C     = W'(P1);
   localparam logic [W-1:0] C2R_C    = W'(C2R);
   localparam logic [W-1:0] C2F_C    = W'(C2F);
   localparam logic [W-1:0] RESUME_C = (E == 0) ? '0 : W'(N - E);

   if (P1 < 1 || P2 < 1 || G1 < 1 || G2 < 1 || E < 0 || E > G2) begin : g_bad_params
      $error("phase_clockgen: inconsistent phase widths, gaps or ext lead");
   end

   typedef enum logic {ST_PARKED = 1'b0, ST_RUN = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   c_q, c_d;
   logic           stop_q, stop_d;
   logic [2:0]     sub_q, sub_d;
   logic           sync_q, sync_d;
   logic           clk1_q, clk1_d, clk2_q, clk2_d;
   logic           clk1_ext_q, clk1_ext_d, clk2_ext_q, clk2_ext_d;
   logic           wrap;
   logic [W-1:0]   ext_c;

   // Position of the ext clocks: the counter seen E cycles into the future, modulo N.
   function automatic logic [W-1:0] lead_pos(input logic [W-1:0] c);
      logic [W:0] s;
      s = {1'b0, c} + (W+1)'(E);
      if (s >= (W+1)'(N)) s = s - (W+1)'(N);
      return s[W-1:0];
   endfunction

   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         state_q    <= ST_PARKED;
         c_q        <= C_LAST;
         stop_q     <= 1'b1;
         sub_q      <= 3'd7;
         sync_q     <= 1'b0;
         clk1_q     <= 1'b0;
         clk2_q     <= 1'b0;
         clk1_ext_q <= 1'b0;
         clk2_ext_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         c_q        <= c_d;
         stop_q     <= stop_d;
         sub_q      <= sub_d;
         sync_q     <= sync_d;
         clk1_q     <= clk1_d;
         clk2_q     <= clk2_d;
         clk1_ext_q <= clk1_ext_d;
         clk2_ext_q <= clk2_ext_d;
      end
   end

   // run is only looked at on the edge entering the clk2-fall slot, so a stop decided there
   // can already mask a clk1_ext pulse that would start in that same slot (E = G2).
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      stop_d  = stop_q;
      wrap    = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (c_q == C_LAST) begin
               if (stop_q) begin
                  state_d = ST_PARKED;
               end else begin
                  c_d  = '0;
                  wrap = 1'b1;
               end
            end else begin
               c_d = c_q + W'(1);
               if (c_q == C_SAMPLE && !run) stop_d = 1'b1;
            end
         end
         ST_PARKED: begin
            if (run) begin
               state_d = ST_RUN;
               stop_d  = 1'b0;
               c_d     = RESUME_C;
               wrap    = (E == 0);
            end
         end
         default: state_d = ST_PARKED;
      endcase
      sub_d  = wrap ? sub_q + 3'd1 : sub_q;
      sync_d = wrap ? (sub_d == 3'd7) : sync_q;
   end

   // Clocks are decoded from the next state and registered, so each describes its own cycle.
   always_comb begin
      ext_c      = lead_pos(c_d);
      clk1_d     = (state_d == ST_RUN) && (c_d < P1_C);
      clk2_d     = (state_d == ST_RUN) && (c_d >= C2R_C) && (c_d < C2F_C);
      clk1_ext_d = (state_d == ST_RUN) && !stop_d && (ext_c < P1_C);
      clk2_ext_d = (state_d == ST_RUN) && (ext_c >= C2R_C) && (ext_c < C2F_C);
   end

   assign clk1     = clk1_q;
   assign clk2     = clk2_q;
   assign clk1_ext = clk1_ext_q;
   assign clk2_ext = clk2_ext_q;
   assign subcycle = sub_q;
   assign sync     = sync_q;
   assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_phase_clockgen.sv
// Bench for phase_clockgen: three instances (E = 4, 0, 10) sharing clock/reset/run,
// a per-cycle scoreboard against a behavioural model, plus directed timing scenarios.
module tb_phase_clockgen;

   logic sysclk = 1'b0;
   logic sysrst_n = 1'b0;
   logic run = 1'b0;

   logic       c1 [3];
   logic       c2 [3];
   logic       e1 [3];
   logic       e2 [3];
   logic [2:0] sub [3];
   logic       sy [3];
   logic       rn [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #10 sysclk = ~sysclk;

   phase_clockgen #(.EXT_CLK_PROP(4)) dut (
      .sysclk(sysclk), .sysrst_n(sysrst_n), .run(run),
      .clk1(c1[0]), .clk2(c2[0]), .clk1_ext(e1[0]), .clk2_ext(e2[0]),
      .subcycle(sub[0]), .sync(sy[0]), .running(rn[0]));

   phase_clockgen #(.EXT_CLK_PROP(0)) dut_e0 (
      .sysclk(sysclk), .sysrst_n(sysrst_n), .run(run),
      .clk1(c1[1]), .clk2(c2[1]), .clk1_ext(e1[1]), .clk2_ext(e2[1]),
      .subcycle(sub[1]), .sync(sy[1]), .running(rn[1]));

   phase_clockgen #(.EXT_CLK_PROP(10)) dut_e10 (
      .sysclk(sysclk), .sysrst_n(sysrst_n), .run(run),
      .clk1(c1[2]), .clk2(c2[2]), .clk1_ext(e1[2]), .clk2_ext(e2[2]),
      .subcycle(sub[2]), .sync(sy[2]), .running(rn[2]));

   // Behavioural model state per instance
   int mc [3]  = '{67, 67, 67};
   bit mst [3] = '{1, 1, 1};
   bit mpk [3] = '{1, 1, 1};
   int msb [3] = '{7, 7, 7};
   bit msy [3] = '{0, 0, 0};

   typedef bit [26:0] exp_t;
   exp_t exp_q[$];

   function automatic int ev(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 0 : 10);
   endfunction

   function automatic void mstep(input int e, input bit r, inout int c, inout bit st,
                                 inout bit pk, inout int sb, inout bit syv);
      if (pk) begin
         if (r) begin
            pk = 1'b0;
            st = 1'b0;
            if (e == 0) begin
               c = 0; sb = (sb + 1) % 8; syv = (sb == 7);
            end else begin
               c = 68 - e;
            end
         end
      end else if (c == 67) begin
         if (st) pk = 1'b1;
         else begin
            c = 0; sb = (sb + 1) % 8; syv = (sb == 7);
         end
      end else begin
         c = c + 1;
         if (c == 58 && !r) st = 1'b1;
      end
   endfunction

   function automatic bit [8:0] mouts(input int e, input int c, input bit st, input bit pk,
                                      input int sb, input bit syv);
      bit on;
      int p;
      on = !pk;
      p  = (c + e) % 68;
      return {on && c < 19, on && c >= 39 && c < 58, on && !st && p < 19,
              on && p >= 39 && p < 58, 3'(sb), syv, on};
   endfunction

   function automatic logic [8:0] obs(input int i);
      return {c1[i], c2[i], e1[i], e2[i], sub[i], sy[i], rn[i]};
   endfunction

   task automatic run_model();
      forever begin
         exp_t w;
         @(posedge sysclk);
         w = '0;
         for (int i = 0; i < 3; i++) begin
            int c; bit st; bit pk; int sb; bit syv;
            c = mc[i]; st = mst[i]; pk = mpk[i]; sb = msb[i]; syv = msy[i];
            if (!sysrst_n) begin
               c = 67; st = 1'b1; pk = 1'b1; sb = 7; syv = 1'b0;
            end else begin
               mstep(ev(i), run, c, st, pk, sb, syv);
            end
            w[i*9 +: 9] = mouts(ev(i), c, st, pk, sb, syv);
            mc[i] = c; mst[i] = st; mpk[i] = pk; msb[i] = sb; msy[i] = syv;
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic run_scoreboard();
      forever begin
         @(negedge sysclk);
         if (exp_q.size() > 0) begin
            exp_t w;
            w = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
               n_cmp++;
               if (obs(i) !== w[i*9 +: 9]) begin
                  n_bad++;
                  $display("FAIL scoreboard E=%0d t=%0t got %b want %b (c1 c2 e1 e2 sub sync run)",
                           ev(i), $time, obs(i), w[i*9 +: 9]);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      sysrst_n = 1'b0;
      run = 1'b0;
      repeat (3) @(negedge sysclk);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({c1[i], c2[i], e1[i], e2[i], sy[i], rn[i]} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs E=%0d got %b want 000000", ev(i),
                     {c1[i], c2[i], e1[i], e2[i], sy[i], rn[i]});
         end
         n_cmp++;
         if (sub[i] !== 3'd7) begin
            n_bad++;
            $display("FAIL reset_subcycle E=%0d got %0d want 7", ev(i), sub[i]);
         end
      end
   endtask

   task automatic test_startup();
      int n;
      sysrst_n = 1'b1;
      run = 1'b1;
      @(negedge sysclk);
      n_cmp++;
      if (e1[0] !== 1'b1 || c1[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL startup_first_edge got ext=%b clk1=%b want 1 0", e1[0], c1[0]);
      end
      n = 0;
      while (c1[0] !== 1'b1 && n < 100) begin @(negedge sysclk); n++; end
      n_cmp++;
      if (n != 4) begin n_bad++; $display("FAIL startup_lead got %0d want 4", n); end
      n_cmp++;
      if (sub[0] !== 3'd0) begin n_bad++; $display("FAIL startup_sub got %0d want 0", sub[0]); end
      for (int k = 0; k < 68; k++) begin
         logic [3:0] want;
         if (k > 0) @(negedge sysclk);
         want = {k < 19, k >= 39 && k <= 57, k < 15 || k >= 64, k >= 35 && k <= 53};
         n_cmp++;
         if ({c1[0], c2[0], e1[0], e2[0]} !== want) begin
            n_bad++;
            $display("FAIL startup_window c=%0d got %b want %b", k, {c1[0], c2[0], e1[0], e2[0]}, want);
         end
      end
      @(negedge sysclk);
      n_cmp++;
      if (c1[0] !== 1'b1 || sub[0] !== 3'd1) begin
         n_bad++;
         $display("FAIL startup_period got clk1=%b sub=%0d want 1 1", c1[0], sub[0]);
      end
   endtask

   task automatic test_eight_cycles();
      int hi;
      hi = 0;
      for (int i = 0; i < 8 * 68; i++) begin
         if (i > 0) @(negedge sysclk);
         if (sy[0] === 1'b1) hi++;
         if (i % 68 == 0) begin
            n_cmp++;
            if (sub[0] !== 3'((1 + i / 68) % 8)) begin
               n_bad++;
               $display("FAIL eight_sub i=%0d got %0d want %0d", i, sub[0], (1 + i / 68) % 8);
            end
         end
         n_cmp++;
         if (rn[0] !== 1'b1 || (c1[0] & c2[0]) !== 1'b0) begin
            n_bad++;
            $display("FAIL eight_run_overlap i=%0d got run=%b c1&c2=%b want 1 0", i, rn[0], c1[0] & c2[0]);
         end
      end
      n_cmp++;
      if (hi != 68) begin n_bad++; $display("FAIL sync_width got %0d want 68", hi); end
   endtask

   task automatic test_stop();
      int n;
      n = 0;
      while (!(mc[0] == 30 && msb[0] == 3) && n < 1000) begin @(negedge sysclk); n++; end
      n_cmp++;
      if (n >= 1000) begin n_bad++; $display("FAIL stop_align got timeout want c=30"); end
      run = 1'b0;
      n = 0;
      while (rn[0] === 1'b1 && n < 100) begin
         @(negedge sysclk);
         n++;
         n_cmp++;
         if (e1[0] !== 1'b0) begin n_bad++; $display("FAIL stop_ext_low n=%0d got 1 want 0", n); end
      end
      n_cmp++;
      if (n != 38) begin n_bad++; $display("FAIL stop_park_time got %0d want 38", n); end
      for (int k = 0; k < 10; k++) begin
         @(negedge sysclk);
         n_cmp++;
         if ({c1[0], c2[0], e1[0], e2[0], rn[0]} !== 5'b0 || sub[0] !== 3'd3) begin
            n_bad++;
            $display("FAIL stop_parked got %b sub=%0d want 00000 sub=3",
                     {c1[0], c2[0], e1[0], e2[0], rn[0]}, sub[0]);
         end
      end
      run = 1'b1;
      @(negedge sysclk);
      n_cmp++;
      if ({e1[0], c1[0], rn[0]} !== 3'b101 || sub[0] !== 3'd3) begin
         n_bad++;
         $display("FAIL resume_edge got ext,clk1,run=%b sub=%0d want 101 sub=3", {e1[0], c1[0], rn[0]}, sub[0]);
      end
      n = 0;
      while (c1[0] !== 1'b1 && n < 100) begin @(negedge sysclk); n++; end
      n_cmp++;
      if (n != 4 || sub[0] !== 3'd4) begin
         n_bad++;
         $display("FAIL resume_lead got %0d sub=%0d want 4 sub=4", n, sub[0]);
      end
      n = 0;
      while (c1[0] === 1'b1 && n < 100) begin @(negedge sysclk); n++; end
      n_cmp++;
      if (n != 19) begin n_bad++; $display("FAIL resume_width got %0d want 19", n); end
   endtask

   task automatic test_glitch();
      int n;
      int s0;
      n = 0;
      while (mc[0] != 10 && n < 200) begin @(negedge sysclk); n++; end
      s0 = msb[0];
      run = 1'b0;
      n = 0;
      while (mc[0] != 20 && n < 100) begin @(negedge sysclk); n++; end
      run = 1'b1;
      for (int k = 0; k < 136; k++) begin
         @(negedge sysclk);
         n_cmp++;
         if (rn[0] !== 1'b1) begin n_bad++; $display("FAIL glitch_running k=%0d got 0 want 1", k); end
      end
      n_cmp++;
      if (sub[0] !== 3'((s0 + 2) % 8)) begin
         n_bad++;
         $display("FAIL glitch_sub got %0d want %0d", sub[0], (s0 + 2) % 8);
      end
   endtask

   task automatic test_ext_override();
      int rises;
      logic pe1, pc2;
      rises = 0;
      pe1 = e1[2];
      pc2 = c2[2];
      for (int k = 0; k < 68; k++) begin
         @(negedge sysclk);
         n_cmp++;
         if ({e1[1], e2[1]} !== {c1[1], c2[1]}) begin
            n_bad++;
            $display("FAIL e0_identity got %b want %b", {e1[1], e2[1]}, {c1[1], c2[1]});
         end
         if (e1[2] === 1'b1 && pe1 === 1'b0) begin
            rises++;
            n_cmp++;
            if (pc2 !== 1'b1 || c2[2] !== 1'b0) begin
               n_bad++;
               $display("FAIL e10_rise_at_c2f got prev/now clk2=%b%b want 10", pc2, c2[2]);
            end
         end
         n_cmp++;
         if ((e1[2] & e2[2]) !== 1'b0 || (e1[2] & c2[2]) !== 1'b0) begin
            n_bad++;
            $display("FAIL e10_overlap got %b%b want 00", e1[2] & e2[2], e1[2] & c2[2]);
         end
         pe1 = e1[2];
         pc2 = c2[2];
      end
      n_cmp++;
      if (rises != 1) begin n_bad++; $display("FAIL e10_rises got %0d want 1", rises); end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (mc[0] != 45 && n < 200) begin @(negedge sysclk); n++; end
      n_cmp++;
      if (c2[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_pre got clk2=%b want 1", c2[0]); end
      #2;
      sysrst_n = 1'b0;
      run = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({c1[i], c2[i], e1[i], e2[i], sy[i], rn[i]} !== 6'b0 || sub[i] !== 3'd7) begin
            n_bad++;
            $display("FAIL midreset_async E=%0d got %b sub=%0d want 000000 sub=7", ev(i),
                     {c1[i], c2[i], e1[i], e2[i], sy[i], rn[i]}, sub[i]);
         end
      end
      repeat (3) @(negedge sysclk);
      sysrst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge sysclk);
         n_cmp++;
         if ({c1[0], c2[0], e1[0], e2[0], rn[0]} !== 5'b0) begin
            n_bad++;
            $display("FAIL midreset_parked got %b want 00000", {c1[0], c2[0], e1[0], e2[0], rn[0]});
         end
      end
      run = 1'b1;
      @(negedge sysclk);
      n = 0;
      while (c1[0] !== 1'b1 && n < 100) begin @(negedge sysclk); n++; end
      n_cmp++;
      if (n != 4 || sub[0] !== 3'd0) begin
         n_bad++;
         $display("FAIL midreset_restart got lead=%0d sub=%0d want 4 sub=0", n, sub[0]);
      end
   endtask

   initial begin
      fork
         run_model();
         run_scoreboard();
      join_none
      test_reset();
      test_startup();
      test_eight_cycles();
      test_stop();
      test_glitch();
      test_ext_override();
      test_reset_mid();
      @(negedge sysclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
